// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and a separate occupancy count;
// a pop frees a slot for a push in the same cycle even when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    // Next-state pointers and count; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        pop_ok_s  = pop_i && (count_q != {CW{1'b0}});
        push_ok_s = push_i && ((count_q != CW'(DEPTH)) || pop_ok_s);
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= din_i;
            end
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == {CW{1'b0}});
    assign count_o = count_q;

endmodule

// File: rtl/a0_uart_tx.sv
// Captures each new byte seen on the core's a0 output port and sends it as
// UART 8N1. tx_o and busy_o follow the FSM state one clock later.
module a0_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic                        en_i,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic                        overflow_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t             state_q;
    logic [BW-1:0]         baud_q;
    logic [2:0]            bit_q;
    logic [DATA_WIDTH-1:0] sh_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic                  tx_q, busy_q, overflow_q;

    logic                  cap_s, pop_s, baud_last_s;
    logic                  fifo_full_s, fifo_empty_s;
    logic [DATA_WIDTH-1:0] fifo_dout_s;

    assign cap_s       = en_i && (data_i != prev_q);
    assign pop_s       = (state_q == IDLE) && !fifo_empty_s;
    assign baud_last_s = (baud_q == BW'(CLKS_PER_BIT - 1));

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cap_s),
        .pop_i   (pop_s),
        .din_i   (data_i),
        .dout_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_o)
    );

    // Change detector and sticky drop flag; prev_q moves only on capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q     <= {DATA_WIDTH{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            if (cap_s) begin
                prev_q <= data_i;
            end
            if (cap_s && fifo_full_s && !pop_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Transmit FSM with baud counter, shift register and registered line outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            baud_q  <= {BW{1'b0}};
            bit_q   <= 3'd0;
            sh_q    <= {DATA_WIDTH{1'b0}};
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= (state_q != IDLE) || !fifo_empty_s;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty_s) begin
                        sh_q    <= fifo_dout_s;
                        baud_q  <= {BW{1'b0}};
                        state_q <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (baud_last_s) begin
                        baud_q  <= {BW{1'b0}};
                        bit_q   <= 3'd0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    tx_q <= sh_q[0];
                    if (baud_last_s) begin
                        baud_q <= {BW{1'b0}};
                        sh_q   <= {1'b0, sh_q[DATA_WIDTH-1:1]};
                        if (bit_q == 3'(UART_DATA_BITS - 1)) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (baud_last_s) begin
                        baud_q  <= {BW{1'b0}};
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    baud_q  <= {BW{1'b0}};
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign overflow_o = overflow_q;

endmodule
